// File: rtl/serial_addsub_if.sv
// rtl/serial_addsub_if.sv - chunk stream bundle between serialiser, serial_addsub and result consumer
interface serial_addsub_if #(
    parameter int N = 4
);
    logic         i_valid;
    logic         i_ready;
    logic [N-1:0] i0;
    logic [N-1:0] i1;
    logic         sub;
    logic         cin;
    logic         o_valid;
    logic         o_ready;
    logic [N-1:0] o;
    logic         o_last;
    logic         cout;
    logic         v;
    logic         z;

    modport master (
        output i_valid, i0, i1, sub, cin, o_ready,
        input  i_ready, o_valid, o, o_last, cout, v, z
    );

    modport slave (
        input  i_valid, i0, i1, sub, cin, o_ready,
        output i_ready, o_valid, o, o_last, cout, v, z
    );
endinterface

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - digit-serial adder/subtractor, N-bit chunks, K chunks per word, LS chunk first
module serial_addsub #(
    parameter int N = 4,
    parameter int K = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    serial_addsub_if.slave      bus
);
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    logic [IW-1:0] idx_q, idx_d;
    logic          mode_q, mode_d;
    logic          carry_q, carry_d;
    logic          zacc_q, zacc_d;
    logic          o_valid_q, o_valid_d;
    logic [N-1:0]  o_q, o_d;
    logic          o_last_q, o_last_d;
    logic          cout_q, cout_d;
    logic          v_q, v_d;
    logic          z_q, z_d;

    logic          accept;
    logic          first;
    logic          last;
    logic          sub_w;
    logic [N-1:0]  b_w;
    logic          cin_w;
    logic [N:0]    sum;
    logic          zacc_new;

    assign bus.i_ready = !o_valid_q || bus.o_ready;
    assign accept      = bus.i_valid && bus.i_ready;
    assign first       = (idx_q == '0);
    assign last        = (idx_q == IW'(K - 1));

    always_comb begin
        // Mode and carry-in come from the ports only on chunk 0; later chunks use the latched state.
        sub_w    = first ? bus.sub : mode_q;
        b_w      = sub_w ? ~bus.i1 : bus.i1;
        cin_w    = first ? (bus.sub ^ bus.cin) : carry_q;
        sum      = {1'b0, bus.i0} + {1'b0, b_w} + {{N{1'b0}}, cin_w};
        zacc_new = (sum[N-1:0] == '0) && (first || zacc_q);

        idx_d    = idx_q;
        mode_d   = mode_q;
        carry_d  = carry_q;
        zacc_d   = zacc_q;
        o_d      = o_q;
        o_last_d = o_last_q;
        cout_d   = cout_q;
        v_d      = v_q;
        z_d      = z_q;

        if (accept) begin
            idx_d    = last ? '0 : idx_q + IW'(1);
            mode_d   = sub_w;
            carry_d  = sum[N];
            zacc_d   = zacc_new;
            o_d      = sum[N-1:0];
            o_last_d = last;
            cout_d   = last && (sub_w ^ sum[N]);
            v_d      = last && (bus.i0[N-1] == b_w[N-1]) && (sum[N-1] != bus.i0[N-1]);
            z_d      = last && zacc_new;
        end

        if (accept) begin
            o_valid_d = 1'b1;
        end else if (bus.o_ready) begin
            o_valid_d = 1'b0;
        end else begin
            o_valid_d = o_valid_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q     <= '0;
            mode_q    <= 1'b0;
            carry_q   <= 1'b0;
            zacc_q    <= 1'b1;
            o_valid_q <= 1'b0;
            o_q       <= '0;
            o_last_q  <= 1'b0;
            cout_q    <= 1'b0;
            v_q       <= 1'b0;
            z_q       <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            mode_q    <= mode_d;
            carry_q   <= carry_d;
            zacc_q    <= zacc_d;
            o_valid_q <= o_valid_d;
            o_q       <= o_d;
            o_last_q  <= o_last_d;
            cout_q    <= cout_d;
            v_q       <= v_d;
            z_q       <= z_d;
        end
    end

    assign bus.o_valid = o_valid_q;
    assign bus.o       = o_q;
    assign bus.o_last  = o_last_q;
    assign bus.cout    = cout_q;
    assign bus.v       = v_q;
    assign bus.z       = z_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - scoreboard bench for serial_addsub against a whole-word arithmetic model
module tb_serial_addsub;
    localparam int N = 4;
    localparam int K = 2;
    localparam int W = N * K;

    typedef struct packed {
        logic [N-1:0] o;
        logic         last;
        logic         cout;
        logic         v;
        logic         z;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   rdy_mode = 1;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    exp_t drop_e;

    serial_addsub_if #(.N(N)) bus ();

    serial_addsub #(.N(N), .K(K)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Consumer ready: random in mode 0, forced 1 / 0 in modes 1 / 2.
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) bus.o_ready = ($urandom_range(0, 3) != 0);
        else               bus.o_ready = (rdy_mode == 1);
    end

    always @(negedge clk) begin
        if (!rst && bus.o_valid === 1'b1 && bus.o_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got o=%0h with no expected chunk at %0t", bus.o, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("o",      32'(bus.o),      32'(mon_e.o));
                check("o_last", 32'(bus.o_last), 32'(mon_e.last));
                check("cout",   32'(bus.cout),   32'(mon_e.cout));
                check("v",      32'(bus.v),      32'(mon_e.v));
                check("z",      32'(bus.z),      32'(mon_e.z));
            end
        end
    end

    task automatic send_chunk(input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic s, input logic c, input exp_t e);
        logic got;
        bus.i0 = a;
        bus.i1 = b;
        bus.sub = s;
        bus.cin = c;
        bus.i_valid = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (bus.i_ready === 1'b1) got = 1'b1;
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL accept_timeout: got i_ready=0 for 100 cycles required 1");
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    // Reference: the whole word as plain N*K-bit arithmetic, then cut into chunks.
    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                             input logic c, input bit noise, input bit stall);
        logic [W:0]   full;
        logic [W-1:0] res;
        logic [3*W-1:0] snap_dummy;
        logic [N+5:0] snap;
        exp_t         e;
        logic         sk, ck;
        full = s ? ({1'b0, a} - {1'b0, b} - (W+1)'(c)) : ({1'b0, a} + {1'b0, b} + (W+1)'(c));
        res  = full[W-1:0];
        snap_dummy = '0;
        if (stall) begin
            rdy_mode = 1;
            bus.i_valid = 1'b0;
            repeat (3) begin @(posedge clk); #2; end
            rdy_mode = 2;
            @(posedge clk); #2;
        end
        for (int k = 0; k < K; k++) begin
            e.o    = res[k*N +: N];
            e.last = (k == K - 1);
            e.cout = e.last && full[W];
            e.v    = e.last && (res[W-1] != a[W-1]) && (s ? (a[W-1] != b[W-1]) : (a[W-1] == b[W-1]));
            e.z    = e.last && (res == '0);
            sk = (k == 0 || !noise) ? s : 1'($urandom);
            ck = (k == 0 || !noise) ? c : 1'($urandom);
            if (stall && k == 1) begin
                bus.i0 = a[k*N +: N];
                bus.i1 = b[k*N +: N];
                bus.i_valid = 1'b1;
                @(negedge clk);
                snap = {bus.o_valid, bus.o, bus.o_last, bus.cout, bus.v, bus.z};
                repeat (3) begin
                    @(negedge clk);
                    check("stall_i_ready", 32'(bus.i_ready), 32'd0);
                    check("stall_hold", 32'({bus.o_valid, bus.o, bus.o_last, bus.cout, bus.v, bus.z}), 32'(snap));
                end
                rdy_mode = 1;
            end
            send_chunk(a[k*N +: N], b[k*N +: N], sk, ck, e);
        end
        bus.i_valid = 1'b0;
    endtask

    initial begin
        exp_t e0;
        bus.i_valid = 1'b0;
        bus.i0 = '0;
        bus.i1 = '0;
        bus.sub = 1'b0;
        bus.cin = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("reset_o_valid", 32'(bus.o_valid), 32'd0);
        check("reset_i_ready", 32'(bus.i_ready), 32'd1);
        check("reset_outputs", 32'({bus.o, bus.o_last, bus.cout, bus.v, bus.z}), 32'd0);
        @(posedge clk); #2;

        rdy_mode = 1;
        send_word(8'h3C, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'h10, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'hA7, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
        send_word(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        send_word(8'h96, 8'h2B, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset after chunk 0 with a carry and a zero chunk pending; the pending output must vanish.
        rdy_mode = 1;
        repeat (3) begin @(posedge clk); #2; end
        rdy_mode = 2;
        @(posedge clk); #2;
        e0 = '{o: 4'h0, last: 1'b0, cout: 1'b0, v: 1'b0, z: 1'b0};
        send_chunk(4'hF, 4'h1, 1'b0, 1'b0, e0);
        bus.i_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        drop_e = exp_q.pop_back();
        @(negedge clk);
        check("midword_reset_o_valid", 32'(bus.o_valid), 32'd0);
        check("midword_reset_i_ready", 32'(bus.i_ready), 32'd1);
        rdy_mode = 1;
        @(posedge clk); #2;
        send_word(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'h80, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);

        rdy_mode = 0;
        for (int i = 0; i < 150; i++) begin
            send_word(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end

        rdy_mode = 1;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
